// File: rtl/systolic_array_feeder.sv
// systolic_array_feeder: command-driven sequencer that loads weights and
// input/partial-sum rows into a systolic array, collects the output rows in
// whatever order the array produces them, and returns them in row order.
module systolic_array_feeder #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int RW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load_w,
  input  logic [1:0]        cmd_gap,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [N*DW-1:0]   src_data,
  input  logic [N*DW-1:0]   src_partial,
  output logic              sa_weight_en,
  output logic              sa_input_en,
  output logic              sa_partial_en,
  output logic [RW-1:0]     sa_row_in_en,
  output logic [RW-1:0]     sa_row_ps_en,
  output logic [N*DW-1:0]   sa_array_in,
  output logic [N*DW-1:0]   sa_array_in_partials,
  input  logic              sa_out_en,
  input  logic [RW-1:0]     sa_row_out,
  input  logic [N*DW-1:0]   sa_array_output,
  input  logic              sa_drained,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_row,
  output logic [N*DW-1:0]   res_data,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WLOAD   = 3'd1;
  localparam logic [2:0] S_WSETTLE = 3'd2;
  localparam logic [2:0] S_INLOAD  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_RESULT  = 3'd6;

  logic [2:0]                 state;
  logic [RW-1:0]              k;       // rows accepted in the current load phase
  logic [1:0]                 gap_q;   // latched inter-row gap
  logic [1:0]                 gcnt;    // remaining gap cycles
  logic [RW-1:0]              r;       // result row being offered
  logic [N-1:0]               mask;    // output rows captured so far
  logic [N-1:0][N*DW-1:0]     rbuf;    // captured output rows, indexed by row

  logic         accept;
  logic         cap_ok;
  logic         res_fire;
  logic [N-1:0] hot;
  logic [N-1:0] mask_nx;

  assign cmd_ready = !rst && (state == S_IDLE);
  assign src_ready = !rst && ((state == S_WLOAD) || (state == S_INLOAD));
  assign accept    = src_valid && src_ready;
  assign cap_ok    = sa_out_en &&
                     ((state == S_INLOAD) || (state == S_GAP) || (state == S_DRAIN));
  assign res_valid = (state == S_RESULT);
  assign res_fire  = res_valid && res_ready;
  assign res_row   = r;
  assign res_data  = res_valid ? rbuf[r] : '0;

  // Mask as it will be after this cycle's capture, so a last row arriving
  // together with sa_drained releases DRAIN on the same edge.
  always_comb begin
    hot = '0;
    if (cap_ok) hot[sa_row_out] = 1'b1;
    mask_nx = mask | hot;
  end

  // Sequencer: command accept, weight/input streaming, gaps, drain, result return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      gap_q <= '0;
      gcnt  <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          gap_q <= cmd_gap;
          k     <= '0;
          r     <= '0;
          state <= cmd_load_w ? S_WLOAD : S_INLOAD;
        end
        S_WLOAD: if (accept) begin
          k <= k + 1'b1;                       // wraps to 0 after row N-1
          if (k == RW'(N-1)) state <= S_WSETTLE;
        end
        S_WSETTLE: state <= S_INLOAD;
        S_INLOAD: if (accept) begin
          k <= k + 1'b1;
          if (k == RW'(N-1)) begin
            state <= S_DRAIN;
          end else if (gap_q != 2'd0) begin
            gcnt  <= gap_q;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          gcnt <= gcnt - 2'd1;
          if (gcnt == 2'd1) state <= S_INLOAD;
        end
        S_DRAIN: if ((&mask_nx) && sa_drained) state <= S_RESULT;
        S_RESULT: if (res_fire) begin
          r <= r + 1'b1;
          if (r == RW'(N-1)) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output-row capture into the reorder buffer, with sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      rbuf <= '0;
      err  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cmd_valid) mask <= '0;
      if (sa_out_en) begin
        if (cap_ok) begin
          rbuf[sa_row_out] <= sa_array_output;
          mask[sa_row_out] <= 1'b1;
          if (mask[sa_row_out]) err <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Registered array strobes: one-cycle pulse per accepted source row, else all zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_weight_en         <= 1'b0;
      sa_input_en          <= 1'b0;
      sa_partial_en        <= 1'b0;
      sa_row_in_en         <= '0;
      sa_row_ps_en         <= '0;
      sa_array_in          <= '0;
      sa_array_in_partials <= '0;
    end else begin
      sa_weight_en         <= 1'b0;
      sa_input_en          <= 1'b0;
      sa_partial_en        <= 1'b0;
      sa_row_in_en         <= '0;
      sa_row_ps_en         <= '0;
      sa_array_in          <= '0;
      sa_array_in_partials <= '0;
      if (accept && (state == S_WLOAD)) begin
        sa_weight_en <= 1'b1;
        sa_row_in_en <= ~k;                  // N-1-k, N being a power of two
        sa_array_in  <= src_data;
      end
      if (accept && (state == S_INLOAD)) begin
        sa_input_en          <= 1'b1;
        sa_partial_en        <= 1'b1;
        sa_row_in_en         <= k;
        sa_row_ps_en         <= k;
        sa_array_in          <= src_data;
        sa_array_in_partials <= src_partial;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Bench for systolic_array_feeder: directed scenarios plus randomized
// operations, checked against a row-level reference of the expected
// strobe order, spacing and returned results.
module tb_systolic_array_feeder;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 2;
  localparam int W  = N * DW;
  typedef logic [W-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_load_w;
  logic [1:0]    cmd_gap;
  logic          src_valid, src_ready;
  row_t          src_data, src_partial;
  logic          sa_weight_en, sa_input_en, sa_partial_en;
  logic [RW-1:0] sa_row_in_en, sa_row_ps_en;
  row_t          sa_array_in, sa_array_in_partials;
  logic          sa_out_en;
  logic [RW-1:0] sa_row_out;
  row_t          sa_array_output;
  logic          sa_drained;
  logic          res_valid, res_ready;
  logic [RW-1:0] res_row;
  row_t          res_data;
  logic          done, err;

  always #5 clk = ~clk;

  systolic_array_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_w(cmd_load_w), .cmd_gap(cmd_gap),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_partial(src_partial),
    .sa_weight_en(sa_weight_en), .sa_input_en(sa_input_en), .sa_partial_en(sa_partial_en),
    .sa_row_in_en(sa_row_in_en), .sa_row_ps_en(sa_row_ps_en),
    .sa_array_in(sa_array_in), .sa_array_in_partials(sa_array_in_partials),
    .sa_out_en(sa_out_en), .sa_row_out(sa_row_out), .sa_array_output(sa_array_output),
    .sa_drained(sa_drained),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data),
    .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log seen by the array side
  int   wq_row[$], wq_cyc[$], iq_row[$], iq_cyc[$];
  row_t wq_dat[$], iq_dat[$], iq_par[$];
  int   odd = 0;
  int   done_cnt = 0;
  bit   mon_on = 1'b0;

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (sa_weight_en) begin
        wq_row.push_back(int'(sa_row_in_en));
        wq_dat.push_back(sa_array_in);
        wq_cyc.push_back(cyc);
        if (sa_row_ps_en != '0 || sa_input_en) odd++;
      end
      if (sa_input_en) begin
        iq_row.push_back(int'(sa_row_in_en));
        iq_dat.push_back(sa_array_in);
        iq_par.push_back(sa_array_in_partials);
        iq_cyc.push_back(cyc);
        if (!sa_partial_en || sa_row_ps_en != sa_row_in_en) odd++;
      end
      if (!sa_weight_en && !sa_input_en &&
          (sa_partial_en || sa_array_in != '0 || sa_array_in_partials != '0 ||
           sa_row_in_en != '0 || sa_row_ps_en != '0)) odd++;
      if (done) done_cnt++;
    end
  end

  row_t wv[N], iv[N], pv[N], ov[N];
  int   ord[N];
  int   exp_err;

  task automatic chk(input string tag, input row_t obs, input row_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chki({tag, "_strb"}, int'({sa_weight_en, sa_input_en, sa_partial_en, sa_row_in_en, sa_row_ps_en}), 0);
    chk({tag, "_pay"}, sa_array_in | sa_array_in_partials, row_t'(0));
    chki({tag, "_ctl"}, int'({src_ready, res_valid, res_row, done, err}), 0);
    chk({tag, "_rdata"}, res_data, row_t'(0));
  endtask

  // Offer N source rows; optionally drop src_valid for stall_len cycles before row stall_at.
  task automatic feed(input bit isw, input int stall_at, input int stall_len);
    int k = 0;
    int stalled = 0;
    int budget = 0;
    bit fire;
    while (k < N && budget < 100) begin
      if (k == stall_at && stalled < stall_len) begin
        src_valid = 1'b0;
        stalled++;
      end else begin
        src_valid   = 1'b1;
        src_data    = isw ? wv[k] : iv[k];
        src_partial = isw ? row_t'({$urandom, $urandom}) : pv[k];
      end
      @(negedge clk);
      fire = src_valid && src_ready;
      tick();
      if (fire) k++;
      budget++;
    end
    src_valid = 1'b0;
    chki(isw ? "feed_w_count" : "feed_i_count", k, N);
  endtask

  task automatic emit(input int row, input row_t d, input bit drn);
    sa_out_en       = 1'b1;
    sa_row_out      = RW'(row);
    sa_array_output = d;
    sa_drained      = drn;
    tick();
    sa_out_en       = 1'b0;
    sa_array_output = '0;
  endtask

  task automatic run_op(input bit lw, input int gap, input int st_at, input int st_len,
                        input bit use_in, input int dup, input bit early, input int hold,
                        input bit bp, input bit rst_mid);
    int   d0;
    int   g;
    row_t d;
    wq_row.delete(); wq_cyc.delete(); wq_dat.delete();
    iq_row.delete(); iq_cyc.delete(); iq_dat.delete(); iq_par.delete();
    d0 = done_cnt;
    chki("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_load_w = lw; cmd_gap = 2'(gap);
    tick();
    cmd_valid = 1'b0;
    chki("cmd_ready_busy", int'(cmd_ready), 0);
    if (lw) feed(1'b1, st_at, st_len);
    feed(1'b0, -1, 0);

    // array side: produce outputs in the chosen order
    if (dup >= 0) emit(dup, row_t'({$urandom, $urandom}), 1'b0);
    for (int j = 0; j < N; j++) begin
      d = use_in ? iv[ord[j]] : row_t'({$urandom, $urandom});
      ov[ord[j]] = d;
      if (j == N-1 && early) begin
        sa_drained = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          chki("drain_hold", int'(res_valid), 0);
        end
      end
      emit(ord[j], d, j == N-1);
    end
    sa_drained = 1'b0;
    chki("drain_exit", int'(res_valid), 1);

    // strobe order and spacing
    chki("w_count", wq_row.size(), lw ? N : 0);
    for (int k = 0; k < wq_row.size() && k < N; k++) begin
      chki("w_row", wq_row[k], N-1-k);
      chk("w_data", wq_dat[k], wv[k]);
      if (k > 0) chki("w_space", wq_cyc[k] - wq_cyc[k-1], 1 + ((k == st_at) ? st_len : 0));
    end
    chki("i_count", iq_row.size(), N);
    for (int k = 0; k < iq_row.size() && k < N; k++) begin
      chki("i_row", iq_row[k], k);
      chk("i_data", iq_dat[k], iv[k]);
      chk("i_part", iq_par[k], pv[k]);
      if (k > 0) chki("i_space", iq_cyc[k] - iq_cyc[k-1], gap + 1);
    end
    if (lw && wq_cyc.size() == N && iq_cyc.size() > 0)
      chki("w_to_i", iq_cyc[0] - wq_cyc[N-1], 2);

    // result side
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chki("hold_valid", int'(res_valid), 1);
      chk("hold_data", res_data, ov[0]);
      tick();
    end
    if (rst_mid) begin
      rst = 1'b1;
      tick();
      chki("mid_rst_cmd_ready", int'(cmd_ready), 0);
      chk_idle_outs("mid_rst");
      rst = 1'b0;
      tick();
      chki("after_rst_cmd_ready", int'(cmd_ready), 1);
      chk_idle_outs("after_rst");
      return;
    end
    for (int r = 0; r < N; r++) begin
      if (bp) begin
        g = $urandom_range(2, 0);
        res_ready = 1'b0;
        repeat (g) tick();
      end
      res_ready = 1'b1;
      @(negedge clk);
      chki("res_valid", int'(res_valid), 1);
      chki("res_row", int'(res_row), r);
      chk("res_data", res_data, ov[r]);
      tick();
    end
    chki("done_pulse", int'(done), 1);
    res_ready = 1'b0;
    tick();
    chki("done_clear", int'(done), 0);
    chki("cmd_ready_back", int'(cmd_ready), 1);
    chki("done_once", done_cnt - d0, 1);
    chki("err_state", int'(err), exp_err);
    chki("strobe_shape", odd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load_w = 1'b0; cmd_gap = 2'd0;
    src_valid = 1'b0; src_data = '0; src_partial = '0;
    sa_out_en = 1'b0; sa_row_out = '0; sa_array_output = '0; sa_drained = 1'b0;
    res_ready = 1'b0;
    tick(); tick();
    chki("rst_cmd_ready", int'(cmd_ready), 0);
    chk_idle_outs("rst");
    rst = 1'b0;
    tick();
    mon_on = 1'b1;
    chki("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk_idle_outs("post_rst");
    exp_err = 0;

    // identity weights, ramp inputs, zero partials, gap 1
    for (int j = 0; j < N; j++) begin
      wv[j] = '0;
      wv[j][j*DW +: DW] = 16'h3C00;
      iv[j] = {N{16'(16'h4000 + j)}};
      pv[j] = '0;
      ord[j] = j;
    end
    run_op(1'b1, 1, -1, 0, 1'b1, -1, 1'b0, 0, 1'b0, 1'b0);
    // inputs only, back-to-back
    run_op(1'b0, 0, -1, 0, 1'b1, -1, 1'b0, 0, 1'b0, 1'b0);
    // source stall of 3 cycles before the third weight row
    for (int j = 0; j < N; j++) begin
      wv[j] = {$urandom, $urandom}; iv[j] = {$urandom, $urandom}; pv[j] = {$urandom, $urandom};
    end
    run_op(1'b1, 0, 2, 3, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0);
    // out-of-order outputs with sa_drained early
    ord[0] = 2; ord[1] = 0; ord[2] = 3; ord[3] = 1;
    run_op(1'b1, 0, -1, 0, 1'b0, -1, 1'b1, 0, 1'b0, 1'b0);

    // randomized operations
    for (int it = 0; it < 6; it++) begin
      bit lw;
      int gp, sa, sl, t, j;
      for (int q = 0; q < N; q++) begin
        wv[q] = {$urandom, $urandom}; iv[q] = {$urandom, $urandom}; pv[q] = {$urandom, $urandom};
        ord[q] = q;
      end
      for (int q = N-1; q > 0; q--) begin
        j = $urandom_range(q, 0);
        t = ord[q]; ord[q] = ord[j]; ord[j] = t;
      end
      lw = 1'($urandom_range(1, 0));
      gp = $urandom_range(3, 0);
      sa = (lw && $urandom_range(1, 0) == 1) ? $urandom_range(N-1, 1) : -1;
      sl = $urandom_range(3, 1);
      run_op(lw, gp, sa, sl, 1'b0, -1, 1'($urandom_range(1, 0)), 0, 1'b1, 1'b0);
    end

    // duplicate capture of row 1: err set, later data wins
    for (int j = 0; j < N; j++) ord[j] = j;
    exp_err = 1;
    run_op(1'b1, 0, -1, 0, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);
    emit(0, row_t'({$urandom, $urandom}), 1'b0);
    chki("err_sticky", int'(err), 1);

    // backpressure in RESULT then reset mid-operation
    run_op(1'b1, 1, -1, 0, 1'b0, -1, 1'b0, 5, 1'b0, 1'b1);

    // spurious output in IDLE on a clean error flag
    chki("err_clean", int'(err), 0);
    emit(3, row_t'({$urandom, $urandom}), 1'b0);
    chki("err_spurious", int'(err), 1);
    tick();
    chki("err_stays", int'(err), 1);
    chki("idle_after_spurious", int'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_feeder.md
# systolic_array_feeder

Hardware sequencer for the memory side of `systolic_array`. It accepts one matrix-operation command and optionally loads N weight rows in reverse row order. It then streams N input/partial-sum row pairs with a programmable gap, captures the N output rows as they emerge in any order, and returns them in row order over a valid/ready port. It sits between the scratchpad/DMA fabric and the array, driving the array's `memory_array` modport signals.

## Interface
- `N`, 4: array dimension (rows, columns); power of two, ≥2.
- `DW`, 16: element width (fp16).
- `RW`, `$clog2(N)`: row-index width (derived).

- `clk`  in  1  clock; all logic rises on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_load_w`  in  1  1 = load weights before inputs.
- `cmd_gap`  in  2  idle cycles inserted between consecutive input rows (0..3).
- `src_valid`  in  1  source row offered.
- `src_ready`  out  1  feeder accepts a source row this cycle.
- `src_data`  in  N*DW  weight row (WLOAD) or input row (INLOAD).
- `src_partial`  in  N*DW  partial-sum row (INLOAD only; ignored in WLOAD).
- `sa_weight_en`, `sa_input_en`, `sa_partial_en`  out  1  array load strobes.
- `sa_row_in_en`, `sa_row_ps_en`  out  RW  target row indices.
- `sa_array_in`, `sa_array_in_partials`  out  N*DW  row payloads.
- `sa_out_en`  in  1  array output row valid.
- `sa_row_out`  in  RW  index of output row.
- `sa_array_output`  in  N*DW  output row.
- `sa_drained`  in  1  array has no computation in flight.
- `res_valid`  out  1  result row offered.
- `res_ready`  in  1  result consumer ready.
- `res_row`  out  RW  result row index.
- `res_data`  out  N*DW  result row.
- `done`  out  1  one-cycle pulse after last result handshake.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, WLOAD, WSETTLE, INLOAD, GAP, DRAIN, RESULT.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_load_w`/`cmd_gap`, clear capture mask, go to WLOAD if `cmd_load_w`, else INLOAD.
- WLOAD: `src_ready`=1. The k-th accepted row (k=0..N-1) targets row N-1-k with `sa_weight_en`=1 and `sa_row_ps_en`=0. After N accepts go to WSETTLE.
- WSETTLE: one idle cycle, all strobes 0, then INLOAD.
- INLOAD: `src_ready`=1. The k-th accepted row drives `sa_input_en`=`sa_partial_en`=1 and `sa_row_in_en`=`sa_row_ps_en`=k. If k<N-1 and gap>0, go to GAP for `cmd_gap` cycles. After the N-th accept go to DRAIN.
- GAP: `src_ready`=0; decrement the counter; return to INLOAD at 0.
- Capture, active in INLOAD/GAP/DRAIN: on `sa_out_en`, write `sa_array_output` to `buf[sa_row_out]` and set `mask[sa_row_out]`.
- Capture errors:
  - `sa_out_en` for a row already in the mask sets `err`; the buffer is overwritten.
  - `sa_out_en` in IDLE/WLOAD/WSETTLE/RESULT sets `err` and is discarded.
- DRAIN: go to RESULT when the mask is all ones and `sa_drained`=1. If `sa_drained`=1 with the mask incomplete, stay in DRAIN.
- RESULT: `res_valid`=1, `res_row`=r, `res_data`=`buf[r]`, r from 0. Each handshake increments r. The handshake at r=N-1 pulses `done` next cycle and returns to IDLE.
- `src_valid`=0 in WLOAD/INLOAD is a bubble: strobes stay 0 and the row counter holds.

## Timing
- Reset values: all `sa_*` outputs, `src_ready`, `res_valid`, `res_row`, `res_data`, `done`, `err` = 0; `cmd_ready`=0 during reset and 1 the first cycle after. State IDLE; mask, counters and buffer cleared.
- `sa_*` outputs are registered. A src handshake at edge t drives the strobe and payload during cycle t..t+1 for exactly one cycle, then returns to 0.
- Back-to-back accepts with `cmd_gap`=0 give one array row per cycle, with no bubbles.
- Weight→input spacing: last weight strobe, one WSETTLE idle cycle, first input strobe earliest the following cycle.
- A capture coincident with the DRAIN exit check counts for that check, so the mask is evaluated including the same-cycle write.
- `rst` mid-operation: next cycle everything is at reset values, and any partially streamed matrix is abandoned.

## Test plan
- Weights = identity (0x3C00 diagonal), inputs row k = all 0x4000+k, partials 0, `cmd_gap`=1, with a `systolic_array` model → weight strobes on rows 3,2,1,0 on consecutive cycles; input strobes spaced 2 cycles; results rows 0..3 equal inputs; `done` pulses once; `err`=0.
- Same data, `cmd_load_w`=0, `cmd_gap`=0 → four input strobes on consecutive cycles, no weight strobes, results match.
- `src_valid` deasserted for 3 cycles mid-WLOAD → no strobes during the stall, row order still 3..0.
- Output rows returned out of order (2,0,3,1), `sa_drained` raised before the last row → DRAIN holds until row 1 is captured; results emerge 0,1,2,3.
- Duplicate `sa_row_out`=1, then spurious `sa_out_en` in IDLE → `err`=1 and stays set; the result for row 1 carries the later data.
- `res_ready` held low 5 cycles, then `rst` asserted in RESULT → `res_valid` holds with stable data; after reset all outputs are 0 and `cmd_ready`=1.
